// File: rtl/sic1_cpu.sv
// sic1_cpu: SUBLEQ execution core for the SIC-1 machine.
// Drives the 8-bit memory bus as initiator; every instruction takes six
// cycles (fetch A, B, C, load mem[A], load mem[B], store mem[A]-mem[B]).
// Optional feature macro: SIC1_STEP_EN adds a single-step input.
module sic1_cpu #(
   parameter logic [7:0] ADDR_HALT = 8'd255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
`ifdef SIC1_STEP_EN
   input  logic       step,
`endif
   output logic [7:0] mem_addr,
   output logic       mem_wr_en,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic [7:0] pc,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_FETCH_A,
      S_FETCH_B,
      S_FETCH_C,
      S_LOAD_A,
      S_LOAD_B,
      S_STORE,
      S_HALT
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] c;
   logic [7:0] va;
   logic [7:0] vb;
   logic [7:0] diff;
   logic       take_branch;
   logic [7:0] next_pc;
   logic       advance;

   assign diff        = va - vb;
   assign take_branch = (diff == 8'd0) || diff[7];
   assign next_pc     = take_branch ? c : (pc + 8'd3);

`ifdef SIC1_STEP_EN
   logic step_armed;

   // Arm single-step once step is seen low in FETCH_A; consume on start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_armed <= 1'b0;
      end else if (state_q == S_FETCH_A) begin
         if (!step) begin
            step_armed <= 1'b1;
         end else if (run && step_armed) begin
            step_armed <= 1'b0;
         end
      end
   end

   assign advance = run && step && step_armed;
`else
   assign advance = run;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH_A;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing and combinational bus decode from state
   always_comb begin
      state_d   = state_q;
      mem_addr  = pc;
      mem_wr_en = 1'b0;
      mem_wdata = 8'd0;
      halted    = 1'b0;
      case (state_q)
         S_FETCH_A: begin
            mem_addr = pc;
            if (advance) begin
               state_d = S_FETCH_B;
            end
         end
         S_FETCH_B: begin
            mem_addr = pc + 8'd1;
            state_d  = S_FETCH_C;
         end
         S_FETCH_C: begin
            mem_addr = pc + 8'd2;
            state_d  = S_LOAD_A;
         end
         S_LOAD_A: begin
            mem_addr = a;
            state_d  = S_LOAD_B;
         end
         S_LOAD_B: begin
            mem_addr = b;
            state_d  = S_STORE;
         end
         S_STORE: begin
            mem_addr  = a;
            mem_wr_en = 1'b1;
            mem_wdata = diff;
            state_d   = (next_pc == ADDR_HALT) ? S_HALT : S_FETCH_A;
         end
         S_HALT: begin
            mem_addr = pc;
            halted   = 1'b1;
         end
         default: begin
            state_d = S_FETCH_A;
         end
      endcase
   end

   // Operand, value and program-counter registers captured per state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= 8'd0;
         a  <= 8'd0;
         b  <= 8'd0;
         c  <= 8'd0;
         va <= 8'd0;
         vb <= 8'd0;
      end else begin
         case (state_q)
            S_FETCH_A: if (advance) a <= mem_rdata;
            S_FETCH_B: b  <= mem_rdata;
            S_FETCH_C: c  <= mem_rdata;
            S_LOAD_A:  va <= mem_rdata;
            S_LOAD_B:  vb <= mem_rdata;
            S_STORE:   pc <= next_pc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sic1_cpu.sv
// tb_sic1_cpu: scoreboard bench for sic1_cpu.
// A SUBLEQ interpreter predicts every store; a monitor pops and checks
// each write the core issues, plus the pc/halted result that follows it.
module tb_sic1_cpu;

   typedef struct packed {
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [7:0]  pc;
      logic [7:0]  npc;
      logic        halt;
      logic [15:0] cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [7:0] pc;
   logic       halted;

   logic [7:0] mem      [256];
   logic [7:0] init_mem [256];
   logic [7:0] ref_mem  [256];
   logic [7:0] prog     [256];

   exp_t q[$];
   int   vectors;
   int   miscompares;
   int   cyc;
   bit   mon_busy;
   bit   exp_halt;
   bit   chk_lat;

`ifdef SIC1_STEP_EN
   logic step;
   logic step_tog;
   logic step_man;
   bit   step_auto;
   assign step = step_auto ? step_tog : step_man;

   // Free-running step toggle so ordinary programs keep executing
   always @(negedge clk) begin
      step_tog = ~step_tog;
   end
`endif

   sic1_cpu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
`ifdef SIC1_STEP_EN
      .step      (step),
`endif
      .mem_addr  (mem_addr),
      .mem_wr_en (mem_wr_en),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .pc        (pc),
      .halted    (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: reloads the image while in reset, writes on store
   always @(posedge clk) begin
      if (!rst_n) begin
         mem <= init_mem;
      end else if (mem_wr_en) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   // Clock count since reset release, used for the latency check
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference SUBLEQ interpreter working on its own memory copy
   task automatic run_model(input int n);
      logic [7:0] p, p1, p2, ia, ib, ic, r, np;
      exp_t e;
      p = 8'd0;
      for (int k = 0; k < n; k++) begin
         p1 = p + 8'd1;
         p2 = p + 8'd2;
         ia = ref_mem[p];
         ib = ref_mem[p1];
         ic = ref_mem[p2];
         r  = ref_mem[ia] - ref_mem[ib];
         ref_mem[ia] = r;
         np = ($signed(r) <= 0) ? ic : p + 8'd3;
         e.addr = ia;
         e.data = r;
         e.pc   = p;
         e.npc  = np;
         e.halt = (np == 8'hFF);
         e.cyc  = 16'(5 + 6 * k);
         q.push_back(e);
         exp_halt = e.halt;
         if (e.halt) break;
         p = np;
      end
   endtask

   task automatic compare_mem(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (mem[i] !== ref_mem[i]) bad++;
      end
      checkOutput(name, bad, 0);
   endtask

   // Monitor: every write strobe must match the next predicted store
   initial begin
      exp_t e;
      mon_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && mem_wr_en) begin
            if (q.size() == 0) begin
               checkOutput("unexpected_write_addr", int'(mem_addr), -1);
            end else begin
               e = q.pop_front();
               mon_busy = 1'b1;
               checkOutput("store_addr", int'(mem_addr), int'(e.addr));
               checkOutput("store_data", int'(mem_wdata), int'(e.data));
               checkOutput("store_pc", int'(pc), int'(e.pc));
               if (chk_lat) checkOutput("store_cycle", cyc, int'(e.cyc));
               @(negedge clk);
               checkOutput("next_pc", int'(pc), int'(e.npc));
               checkOutput("halted", int'(halted), int'(e.halt));
               mon_busy = 1'b0;
            end
         end
      end
   end

   // Load prog, run the core from reset and wait for all predicted stores
   task automatic applyStimulus(input string name, input int n);
      int budget;
      rst_n = 1'b0;
      run   = 1'b1;
      q.delete();
      init_mem = prog;
      ref_mem  = prog;
      exp_halt = 1'b0;
      repeat (2) @(posedge clk);
      run_model(n);
      @(negedge clk);
      rst_n  = 1'b1;
      budget = 0;
      while ((q.size() != 0 || mon_busy) && budget < 10 * n + 40) begin
         @(negedge clk);
         budget++;
      end
      checkOutput({name, "_pending"}, q.size() + int'(mon_busy), 0);
      if (exp_halt) begin
         repeat (10) @(negedge clk);
         checkOutput({name, "_halted"}, int'(halted), 1);
         checkOutput({name, "_wr_after_halt"}, int'(mem_wr_en), 0);
         checkOutput({name, "_halt_pc"}, int'(pc), 255);
      end
      compare_mem({name, "_mem"});
      rst_n = 1'b0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 8'd0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      chk_lat     = 1'b1;
      rst_n       = 1'b0;
      run         = 1'b0;
`ifdef SIC1_STEP_EN
      chk_lat   = 1'b0;
      step_tog  = 1'b0;
      step_man  = 1'b0;
      step_auto = 1'b1;
`endif
      clear_prog();
      init_mem = prog;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset values");
      checkOutput("rst_pc", int'(pc), 0);
      checkOutput("rst_halted", int'(halted), 0);
      checkOutput("rst_wr_en", int'(mem_wr_en), 0);
      checkOutput("rst_wdata", int'(mem_wdata), 0);
      checkOutput("rst_addr", int'(mem_addr), 0);

      $display("[TB] basic subtract");
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd0;
      prog[10] = 8'd5; prog[11] = 8'd3;
      applyStimulus("basic", 1);

      $display("[TB] branch taken, zero result");
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'h20;
      prog[10] = 8'd3; prog[11] = 8'd3;
      applyStimulus("br_zero", 1);

      $display("[TB] branch taken, negative result");
      prog[10] = 8'd1; prog[11] = 8'd2;
      applyStimulus("br_neg", 1);

      $display("[TB] signed wrap does not branch");
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'h40;
      prog[10] = 8'h80; prog[11] = 8'h01;
      applyStimulus("wrap", 1);

      $display("[TB] halt with I/O addresses");
      clear_prog();
      prog[0] = 8'd254; prog[1] = 8'd253; prog[2] = 8'd255;
      prog[253] = 8'h2A; prog[254] = 8'h00;
      applyStimulus("halt_io", 4);

      $display("[TB] fall-through halt at pc 252");
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd252;
      prog[10] = 8'd1; prog[11] = 8'd1;
      prog[252] = 8'd20; prog[253] = 8'd21; prog[254] = 8'd0;
      prog[20] = 8'd5; prog[21] = 8'd1;
      applyStimulus("fall_halt", 4);

      $display("[TB] fetch wraps past 255");
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd254;
      prog[10] = 8'd2; prog[11] = 8'd7;
      prog[254] = 8'd30; prog[255] = 8'd31;
      prog[30] = 8'd9; prog[31] = 8'd4;
      applyStimulus("fetch_wrap", 3);

`ifndef SIC1_STEP_EN
      $display("[TB] reset during LOAD_B");
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd0;
      prog[10] = 8'd5; prog[11] = 8'd3;
      init_mem = prog;
      ref_mem  = prog;
      q.delete();
      run = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("loadb_addr", int'(mem_addr), 11);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_wr_en", int'(mem_wr_en), 0);
      checkOutput("abort_pc", int'(pc), 0);
      checkOutput("abort_addr", int'(mem_addr), 0);
      compare_mem("abort_mem");
`endif

      $display("[TB] run low holds pc");
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd0;
      prog[10] = 8'd5; prog[11] = 8'd3;
      init_mem = prog;
      ref_mem  = prog;
      q.delete();
      rst_n = 1'b0;
      run   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("hold_pc", int'(pc), 0);
      checkOutput("hold_addr", int'(mem_addr), 0);
      compare_mem("hold_mem");
      rst_n = 1'b0;

`ifdef SIC1_STEP_EN
      $display("[TB] single step held high");
      step_auto = 1'b0;
      step_man  = 1'b0;
      clear_prog();
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd0;
      prog[10] = 8'd5; prog[11] = 8'd3;
      init_mem = prog;
      ref_mem  = prog;
      q.delete();
      run = 1'b1;
      repeat (2) @(posedge clk);
      run_model(1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      step_man = 1'b1;
      repeat (10) @(negedge clk);
      step_man = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("step_pending", q.size(), 0);
      checkOutput("step_pc", int'(pc), 3);
      compare_mem("step_mem");
      rst_n     = 1'b0;
      step_auto = 1'b1;
`endif

      $display("[TB] random programs");
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
         applyStimulus("random", int'($urandom_range(5, 25)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
